fir_axis_obuf: RTL and testbench

Output elastic buffer placed directly downstream of the FIR's AXI-Stream master port (sm_*). It absorbs FIR results while the consumer stalls and re-presents them on an AXI-Stream master with tlast preserved. It also provides per-frame bookkeeping: a sample counter, a frame counter and a done pulse. Software polls these through the system's AXI-Lite wrapper.

---
 rtl/fir_axis_obuf.sv | 121 ++++++++++++
 tb/tb_fir_axis_obuf.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_axis_obuf.sv
// ============================================================================
//  Module   : fir_axis_obuf
//  Purpose  : Output elastic buffer behind the FIR AXI-Stream master, with
//             per-frame sample/frame counters and a frame-done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_axis_obuf #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 8,
    parameter int pLOG2_DEPTH = 3
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   flush,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [pLOG2_DEPTH:0]   count,
    output logic [31:0]            sample_cnt,
    output logic [31:0]            frame_cnt,
    output logic                   frame_done
);

    localparam int c_PTR_W = pLOG2_DEPTH + 1;

    // Each entry holds {tlast, tdata}
    logic [pDATA_WIDTH:0] mem_q [pDEPTH];

    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]        sample_cnt_q, sample_cnt_d;
    logic [31:0]        frame_cnt_q, frame_cnt_d;
    logic               frame_done_q, frame_done_d;
    logic               ready_q;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [pDATA_WIDTH:0] w_head;

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[pLOG2_DEPTH-1:0] == rd_ptr_q[pLOG2_DEPTH-1:0]) &&
                     (wr_ptr_q[pLOG2_DEPTH] != rd_ptr_q[pLOG2_DEPTH]);

    assign w_head  = mem_q[rd_ptr_q[pLOG2_DEPTH-1:0]];

    assign s_tready   = ready_q & ~w_full;
    assign m_tvalid   = ~w_empty;
    assign m_tdata    = w_head[pDATA_WIDTH-1:0];
    assign m_tlast    = w_head[pDATA_WIDTH];
    assign count      = wr_ptr_q - rd_ptr_q;
    assign sample_cnt = sample_cnt_q;
    assign frame_cnt  = frame_cnt_q;
    assign frame_done = frame_done_q;

    assign w_push = s_tvalid & s_tready;
    assign w_pop  = m_tvalid & m_tready;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        sample_cnt_d = sample_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        // Flush discards any handshake on the same edge but keeps frame stats
        if (flush) begin
            rd_ptr_d     = wr_ptr_q;
            sample_cnt_d = 32'd0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (m_tlast) begin
                    frame_cnt_d  = frame_cnt_q + 32'd1;
                    sample_cnt_d = 32'd0;
                    frame_done_d = 1'b1;
                end else begin
                    sample_cnt_d = sample_cnt_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            sample_cnt_q <= 32'd0;
            frame_cnt_q  <= 32'd0;
            frame_done_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            sample_cnt_q <= sample_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            ready_q      <= 1'b1;
        end
    end

    // Storage needs no reset; occupancy is defined purely by the pointers
    always_ff @(posedge axis_clk) begin
        if (axis_rst_n && w_push && !flush) begin
            mem_q[wr_ptr_q[pLOG2_DEPTH-1:0]] <= {s_tlast, s_tdata};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_axis_obuf.sv
// ============================================================================
//  Module   : tb_fir_axis_obuf
//  Purpose  : Scoreboard-based bench for the FIR output elastic buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_axis_obuf;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int LOG2  = 3;

    logic            clk = 1'b0;
    logic            axis_rst_n;
    logic            flush;
    logic            s_tvalid;
    logic [DW-1:0]   s_tdata;
    logic            s_tlast;
    logic            s_tready;
    logic            m_tvalid;
    logic [DW-1:0]   m_tdata;
    logic            m_tlast;
    logic            m_tready;
    logic [LOG2:0]   count;
    logic [31:0]     sample_cnt;
    logic [31:0]     frame_cnt;
    logic            frame_done;

    int errors = 0;
    int checks = 0;

    logic [DW:0] sb_q [$];

    always #5 clk = ~clk;

    fir_axis_obuf #(
        .pDATA_WIDTH (DW),
        .pDEPTH      (DEPTH),
        .pLOG2_DEPTH (LOG2)
    ) dut (
        .axis_clk   (clk),
        .axis_rst_n (axis_rst_n),
        .flush      (flush),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .count      (count),
        .sample_cnt (sample_cnt),
        .frame_cnt  (frame_cnt),
        .frame_done (frame_done)
    );

    // Scoreboard: inputs are stable at the falling edge, so handshakes seen
    // here are exactly those the next rising edge will perform.
    always @(negedge clk) begin
        if (axis_rst_n !== 1'b1) begin
            sb_q.delete();
        end else if (flush === 1'b1) begin
            sb_q.delete();
        end else begin
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got %h tlast=%b, required no word", m_tdata, m_tlast);
                end else begin
                    logic [DW:0] exp_w;
                    exp_w = sb_q.pop_front();
                    if ({m_tlast, m_tdata} !== exp_w) begin
                        errors++;
                        $display("FAIL pop_data: got tlast=%b data=%h, required tlast=%b data=%h",
                                 m_tlast, m_tdata, exp_w[DW], exp_w[DW-1:0]);
                    end
                end
            end
            if (s_tvalid === 1'b1 && s_tready === 1'b1)
                sb_q.push_back({s_tlast, s_tdata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name);
        int budget;
        budget = 0;
        m_tready = 1'b1;
        while (m_tvalid !== 1'b0 && budget < 200) begin
            tick();
            budget++;
        end
        m_tready = 1'b0;
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain_timeout: m_tvalid=%b, required 0", name, m_tvalid);
        end
    endtask

    task automatic test_reset();
        axis_rst_n = 1'b0;
        flush      = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tlast    = 1'b0;
        m_tready   = 1'b0;
        repeat (3) tick();
        checks++;
        if ({s_tready, m_tvalid, count, frame_cnt, sample_cnt, frame_done} !== '0) begin
            errors++;
            $display("FAIL reset_state: s_tready=%b m_tvalid=%b count=%0d frame_cnt=%0d sample_cnt=%0d frame_done=%b, required all 0",
                     s_tready, m_tvalid, count, frame_cnt, sample_cnt, frame_done);
        end
        axis_rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_release: s_tready=%b, required 0", s_tready);
        end
        tick();
        checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || count !== 0) begin
            errors++;
            $display("FAIL idle_state: s_tready=%b m_tvalid=%b count=%0d, required 1 0 0", s_tready, m_tvalid, count);
        end
    endtask

    task automatic test_fill();
        int budget;
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            s_tdata = DW'(i);
            tick();
        end
        checks++;
        if (count !== 4'd8 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: count=%0d s_tready=%b, required 8 0", count, s_tready);
        end
        s_tdata = DW'(9);
        repeat (3) tick();
        checks++;
        if (count !== 4'd8 || m_tdata !== DW'(1)) begin
            errors++;
            $display("FAIL fill_holdoff: count=%0d head=%0d, required 8 1", count, m_tdata);
        end
        m_tready = 1'b1;
        budget   = 0;
        while (s_tready !== 1'b1 && budget < 50) begin
            tick();
            budget++;
        end
        tick();
        s_tvalid = 1'b0;
        checks++;
        if (budget >= 50) begin
            errors++;
            $display("FAIL fill_ninth_accept: s_tready never rose, required 1");
        end
        wait_empty("fill");
    endtask

    task automatic test_back_to_back();
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_tdata = DW'(100 + i);
            if (i > 0) begin
                checks++;
                if (count !== 4'd1 || s_tready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_count[%0d]: count=%0d s_tready=%b, required 1 1", i, count, s_tready);
                end
            end
            tick();
        end
        s_tvalid = 1'b0;
        wait_empty("b2b");
    endtask

    function automatic logic [DW-1:0] sample_val(input int f, input int k);
        int v;
        v = ((k * 37 + f * 11) % 201) - 100;
        return DW'(v);
    endfunction

    task automatic test_frames();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (sample_cnt !== 32'd0 || frame_cnt !== 32'd0) begin
            errors++;
            $display("FAIL frame_pre_flush: sample_cnt=%0d frame_cnt=%0d, required 0 0", sample_cnt, frame_cnt);
        end
        for (int f = 0; f < 3; f++) begin
            fork
                begin : pusher
                    int budget;
                    for (int k = 0; k < 600; k++) begin
                        s_tdata  = sample_val(f, k);
                        s_tlast  = (k == 599);
                        s_tvalid = 1'b1;
                        budget   = 0;
                        while (s_tready !== 1'b1 && budget < 100) begin
                            tick();
                            budget++;
                        end
                        tick();
                        s_tvalid = 1'b0;
                        s_tlast  = 1'b0;
                        repeat (16) tick();
                    end
                end
                begin : popper
                    int budget;
                    for (int k = 0; k < 600; k++) begin
                        budget = 0;
                        while (m_tvalid !== 1'b1 && budget < 100) begin
                            tick();
                            budget++;
                        end
                        if (k == 599) begin
                            checks++;
                            if (sample_cnt !== 32'd599 || m_tlast !== 1'b1) begin
                                errors++;
                                $display("FAIL frame%0d_pre_last: sample_cnt=%0d m_tlast=%b, required 599 1", f, sample_cnt, m_tlast);
                            end
                        end else if (sample_cnt !== 32'(k)) begin
                            checks++;
                            errors++;
                            $display("FAIL frame%0d_sample_cnt[%0d]: got %0d, required %0d", f, k, sample_cnt, k);
                        end
                        m_tready = 1'b1;
                        tick();
                        m_tready = 1'b0;
                        if (k == 599) begin
                            checks++;
                            if (frame_done !== 1'b1 || frame_cnt !== 32'(f + 1) || sample_cnt !== 32'd0) begin
                                errors++;
                                $display("FAIL frame%0d_end: frame_done=%b frame_cnt=%0d sample_cnt=%0d, required 1 %0d 0",
                                         f, frame_done, frame_cnt, sample_cnt, f + 1);
                            end
                            tick();
                            checks++;
                            if (frame_done !== 1'b0) begin
                                errors++;
                                $display("FAIL frame%0d_pulse_width: frame_done=%b, required 0", f, frame_done);
                            end
                        end
                        repeat (16) tick();
                    end
                end
            join
        end
        checks++;
        if (frame_cnt !== 32'd3) begin
            errors++;
            $display("FAIL frame_total: frame_cnt=%0d, required 3", frame_cnt);
        end
    endtask

    task automatic test_flush();
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_tdata = DW'(200 + i);
            tick();
        end
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL flush_prefill: count=%0d, required 5", count);
        end
        s_tdata = DW'(999);
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        s_tvalid = 1'b0;
        checks++;
        if (count !== 0 || m_tvalid !== 1'b0 || frame_cnt !== 32'd3 || sample_cnt !== 32'd0) begin
            errors++;
            $display("FAIL flush_state: count=%0d m_tvalid=%b frame_cnt=%0d sample_cnt=%0d, required 0 0 3 0",
                     count, m_tvalid, frame_cnt, sample_cnt);
        end
        s_tvalid = 1'b1;
        s_tdata  = DW'(300);
        tick();
        s_tvalid = 1'b0;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== DW'(300) || count !== 4'd1) begin
            errors++;
            $display("FAIL flush_next_word: m_tvalid=%b head=%0d count=%0d, required 1 300 1", m_tvalid, m_tdata, count);
        end
        wait_empty("flush");
    endtask

    task automatic test_reset_mid_frame();
        bit saw_pulse;
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_tdata = DW'(400 + i);
            tick();
        end
        s_tvalid = 1'b0;
        checks++;
        if (count !== 4'd4) begin
            errors++;
            $display("FAIL rst_mid_prefill: count=%0d, required 4", count);
        end
        axis_rst_n = 1'b0;
        tick();
        axis_rst_n = 1'b1;
        checks++;
        if ({s_tready, m_tvalid, count, frame_cnt, sample_cnt, frame_done} !== '0) begin
            errors++;
            $display("FAIL rst_mid_state: s_tready=%b m_tvalid=%b count=%0d frame_cnt=%0d sample_cnt=%0d frame_done=%b, required all 0",
                     s_tready, m_tvalid, count, frame_cnt, sample_cnt, frame_done);
        end
        m_tready  = 1'b1;
        saw_pulse = 1'b0;
        repeat (4) begin
            tick();
            if (frame_done !== 1'b0) saw_pulse = 1'b1;
        end
        checks++;
        if (saw_pulse || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_done: saw_pulse=%b m_tvalid=%b, required 0 0", saw_pulse, m_tvalid);
        end
        s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tdata = DW'(-5 - i);
            s_tlast = (i == 2);
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        wait_empty("rst_mid");
        checks++;
        if (frame_cnt !== 32'd1 || sample_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_frame: frame_cnt=%0d sample_cnt=%0d, required 1 0", frame_cnt, sample_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_frames();
        test_flush();
        test_reset_mid_frame();
        repeat (2) tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d words, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
